// File: rtl/prbs_gen_chk_if.sv
// Bus between the PRBS generator/checker and its user: generator controls and
// word output, checker word input, and the host-visible checker status.
interface prbs_gen_chk_if #(
    parameter int W         = 1,
    parameter int ERR_CNT_W = 16
);
    logic [1:0]           mode;
    logic                 gen_en;
    logic                 inj_err;
    logic [W-1:0]         gen_data;
    logic                 gen_valid;
    logic                 chk_valid;
    logic [W-1:0]         chk_data;
    logic                 clr_cnt;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_cnt;

    // Side that drives the controls and the received word.
    modport master (
        output mode, gen_en, inj_err, chk_valid, chk_data, clr_cnt,
        input  gen_data, gen_valid, locked, err_pulse, err_cnt
    );

    // The PRBS block itself.
    modport slave (
        input  mode, gen_en, inj_err, chk_valid, chk_data, clr_cnt,
        output gen_data, gen_valid, locked, err_pulse, err_cnt
    );
endinterface

// File: rtl/prbs_gen_chk.sv
// PRBS generator and self-synchronising checker, W bits per clock, four
// run-time polynomials. The checker hunts by loading received bits into its
// history, then free-runs on predicted bits once locked and counts bit errors.
// rst_n is an asynchronous reset that is asserted HIGH in this codebase.
module prbs_gen_chk #(
    parameter int W           = 1,
    parameter int ERR_CNT_W   = 16,
    parameter int LOCK_CNT    = 8,
    parameter int UNLOCK_ERRS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    prbs_gen_chk_if.slave    bus
);
    localparam int CW    = $clog2(LOCK_CNT + 1);
    localparam int UW    = $clog2(UNLOCK_ERRS + 1);
    localparam int PW    = $clog2(W + 1);
    localparam int SUM_W = ERR_CNT_W + PW;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    typedef enum logic {HUNT, LOCKED} state_e;

    // Oldest bit of the active N-bit window (N = 7/15/23/31).
    function automatic logic top_bit(input logic [30:0] s, input logic [1:0] m);
        case (m)
            2'b00:   top_bit = s[6];
            2'b01:   top_bit = s[14];
            2'b10:   top_bit = s[22];
            default: top_bit = s[30];
        endcase
    endfunction

    // Feedback tap (6/14/18/28) xor'ed with the oldest bit gives the next bit.
    function automatic logic next_bit(input logic [30:0] s, input logic [1:0] m);
        logic tap;
        case (m)
            2'b00:   tap = s[5];
            2'b01:   tap = s[13];
            2'b10:   tap = s[17];
            default: tap = s[27];
        endcase
        next_bit = top_bit(s, m) ^ tap;
    endfunction

    // Shift one bit in and keep only the low N bits of the selected polynomial.
    function automatic logic [30:0] shift_in(input logic [30:0] s, input logic [1:0] m,
                                             input logic b);
        logic [30:0] mask;
        case (m)
            2'b00:   mask = 31'h0000_007F;
            2'b01:   mask = 31'h0000_7FFF;
            2'b10:   mask = 31'h007F_FFFF;
            default: mask = 31'h7FFF_FFFF;
        endcase
        shift_in = {s[29:0], b} & mask;
    endfunction

    logic [30:0]          lfsr_q, lfsr_d;
    logic [W-1:0]         gen_data_q, gen_data_d;
    logic                 gen_valid_q, gen_valid_d;
    logic [1:0]           mode_q, mode_d;
    state_e               state_q, state_d;
    logic [30:0]          hist_q, hist_d;
    logic [CW-1:0]        clean_q, clean_d;
    logic [UW-1:0]        bad_q, bad_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 mode_chg;
    logic [30:0]          gen_s;
    logic [W-1:0]         gen_word;
    logic [30:0]          chk_hp, chk_hr;
    logic [W-1:0]         chk_rx;
    logic                 chk_rx_b, chk_pred_b;
    logic [PW-1:0]        chk_errs;
    logic                 chk_err, chk_clean;
    logic [SUM_W-1:0]     err_sum;

    assign mode_chg = (bus.mode != mode_q);

    // Generator: unroll W LFSR steps per enabled cycle, oldest bit lands at W-1.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        lfsr_d      = lfsr_q;
        gen_data_d  = gen_data_q;
        gen_valid_d = 1'b0;
        mode_d      = bus.mode;
        gen_s       = lfsr_q;
        gen_word    = '0;
        if (mode_chg) begin
            lfsr_d = 31'd1;
        end else if (bus.gen_en) begin
            for (int i = 0; i < W; i++) begin
                gen_word = (gen_word << 1) | W'(top_bit(gen_s, bus.mode));
                gen_s    = shift_in(gen_s, bus.mode, next_bit(gen_s, bus.mode));
            end
            lfsr_d      = gen_s;
            gen_data_d  = gen_word ^ W'(bus.inj_err);
            gen_valid_d = 1'b1;
        end
    end

    // Checker datapath: per-bit prediction, mismatch count and both candidate histories.
    always_comb begin
        chk_hp     = hist_q;
        chk_hr     = hist_q;
        chk_rx     = bus.chk_data;
        chk_rx_b   = 1'b0;
        chk_pred_b = 1'b0;
        chk_errs   = '0;
        for (int i = 0; i < W; i++) begin
            chk_rx_b   = chk_rx[W-1];
            chk_rx     = chk_rx << 1;
            chk_pred_b = next_bit(chk_hp, bus.mode);
            chk_errs   = chk_errs + PW'(chk_rx_b ^ chk_pred_b);
            chk_hp     = shift_in(chk_hp, bus.mode, (state_q == LOCKED) ? chk_pred_b : chk_rx_b);
            chk_hr     = shift_in(chk_hr, bus.mode, chk_rx_b);
        end
        chk_err   = (chk_errs != '0);
        chk_clean = !chk_err && (chk_hr != '0);
        err_sum   = SUM_W'(err_cnt_q) + SUM_W'(chk_errs);
    end

    // Lock state machine and saturating error counter; clr_cnt has the last word.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        clean_d     = clean_q;
        bad_d       = bad_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (mode_chg) begin
            state_d = HUNT;
            clean_d = '0;
            bad_d   = '0;
        end else if (bus.chk_valid) begin
            if (state_q == HUNT) begin
                hist_d = chk_hr;
                if (!chk_clean) begin
                    clean_d = '0;
                end else if (clean_q == CW'(LOCK_CNT - 1)) begin
                    state_d = LOCKED;
                    clean_d = '0;
                    bad_d   = '0;
                end else begin
                    clean_d = clean_q + 1'b1;
                end
            end else begin
                err_cnt_d = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_CNT_W-1:0];
                if (!chk_err) begin
                    bad_d  = '0;
                    hist_d = chk_hp;
                end else begin
                    err_pulse_d = 1'b1;
                    if (bad_q == UW'(UNLOCK_ERRS - 1)) begin
                        state_d = HUNT;
                        hist_d  = chk_hr;
                        bad_d   = '0;
                        clean_d = '0;
                    end else begin
                        bad_d  = bad_q + 1'b1;
                        hist_d = chk_hp;
                    end
                end
            end
        end
        if (bus.clr_cnt) begin
            err_cnt_d = '0;
        end
    end

    // All state registers; reset asserts on a rising rst_n.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lfsr_q      <= 31'd1;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
            mode_q      <= 2'b00;
            state_q     <= HUNT;
            hist_q      <= '0;
            clean_q     <= '0;
            bad_q       <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            lfsr_q      <= lfsr_d;
            gen_data_q  <= gen_data_d;
            gen_valid_q <= gen_valid_d;
            mode_q      <= mode_d;
            state_q     <= state_d;
            hist_q      <= hist_d;
            clean_q     <= clean_d;
            bad_q       <= bad_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.gen_data  = gen_data_q;
    assign bus.gen_valid = gen_valid_q;
    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_prbs_gen_chk.sv
// Directed bench for prbs_gen_chk: a W=1 instance for the PRBS7 sequence and
// a W=8, 4-bit-counter instance for loopback lock, errors, saturation and reset.
module tb_prbs_gen_chk;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prbs_gen_chk_if #(.W(1), .ERR_CNT_W(16)) b1 ();
    prbs_gen_chk_if #(.W(8), .ERR_CNT_W(4))  b8 ();

    prbs_gen_chk #(.W(1), .ERR_CNT_W(16), .LOCK_CNT(8), .UNLOCK_ERRS(4)) u_w1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));
    prbs_gen_chk #(.W(8), .ERR_CNT_W(4), .LOCK_CNT(8), .UNLOCK_ERRS(4)) u_w8 (
        .clk(clk), .rst_n(rst_n), .bus(b8.slave));

    // W=8 checker input: loopback of the generator (optionally corrupted) or a bench word.
    logic       loop_en;
    logic [7:0] flip;
    logic       tb_valid;
    logic [7:0] tb_data;
    assign b8.chk_valid = loop_en ? b8.gen_valid : tb_valid;
    assign b8.chk_data  = loop_en ? (b8.gen_data ^ flip) : tb_data;
    assign b1.chk_valid = b1.gen_valid;
    assign b1.chk_data  = b1.gen_data;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run until locked (bounded), counting the words the checker consumed.
    task automatic wait_lock(input string tag, input int already, input int max_words);
        int words = already;
        for (int c = 0; c < 64 && b8.locked !== 1'b1; c++) begin
            if (b8.chk_valid === 1'b1) words++;
            tick();
        end
        check({tag, "_locked"}, 32'(b8.locked), 32'd1);
        check({tag, "_lock_words"}, 32'(words <= max_words), 32'd1);
    endtask

    // PRBS7 output bits o0..o13, o0 in the MSB: six zeros, the seed one, then o[n]=o[n-7]^o[n-6].
    logic [13:0] exp7 = 14'b00000010000011;
    // First five PRBS31 bytes at W=8: bit 30 of the stream is the seed one.
    logic [7:0]  exp31 [5] = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unl;
        int pul;
        b1.mode = 2'b00; b1.gen_en = 0; b1.inj_err = 0; b1.clr_cnt = 0;
        b8.mode = 2'b11; b8.gen_en = 0; b8.inj_err = 0; b8.clr_cnt = 0;
        loop_en = 1'b1; flip = 8'h00; tb_valid = 1'b0; tb_data = 8'h00;

        // Reset values.
        #1 rst_n = 1'b1;
        #1;
        check("rst_gen_data",  32'(b8.gen_data),  32'h0);
        check("rst_gen_valid", 32'(b8.gen_valid), 32'h0);
        check("rst_locked",    32'(b8.locked),    32'h0);
        check("rst_err_pulse", 32'(b8.err_pulse), 32'h0);
        check("rst_err_cnt",   32'(b8.err_cnt),   32'h0);
        tick(); tick();
        rst_n = 1'b0;

        // Test 1: PRBS7 at W=1, first 14 bits and again one period (127) later.
        b1.gen_en = 1'b1;
        for (int k = 0; k < 14; k++) begin
            tick();
            check($sformatf("t1_bit%0d", k), 32'(b1.gen_data), 32'(exp7[13-k]));
        end
        check("t1_valid", 32'(b1.gen_valid), 32'd1);
        for (int k = 14; k < 127; k++) tick();
        for (int k = 0; k < 14; k++) begin
            tick();
            check($sformatf("t1_period_bit%0d", k), 32'(b1.gen_data), 32'(exp7[13-k]));
        end
        b1.gen_en = 1'b0;
        tick();
        check("t1_hold_valid", 32'(b1.gen_valid), 32'd0);
        check("t1_hold_data",  32'(b1.gen_data),  32'd1);
        b1.inj_err = 1'b1;
        tick();
        check("t1_inj_no_en",  32'(b1.gen_data),  32'd1);
        b1.inj_err = 1'b0;

        // Test 2: PRBS31 at W=8 in loopback; first words, lock time, clean run.
        b8.gen_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("t2_word%0d", k), 32'(b8.gen_data), 32'(exp31[k]));
        end
        wait_lock("t2", 4, 13);
        unl = 0; pul = 0;
        for (int k = 0; k < 2000; k++) begin
            tick();
            if (b8.locked !== 1'b1) unl++;
            if (b8.err_pulse !== 1'b0) pul++;
        end
        check("t2_unlocked_cycles", 32'(unl), 32'd0);
        check("t2_err_pulses",      32'(pul), 32'd0);
        check("t2_err_cnt",         32'(b8.err_cnt), 32'd0);

        // Test 3: one injected error while locked.
        b8.inj_err = 1'b1;
        tick();
        b8.inj_err = 1'b0;
        pul = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (b8.err_pulse === 1'b1) pul++;
        end
        check("t3_err_pulses", 32'(pul), 32'd1);
        check("t3_err_cnt",    32'(b8.err_cnt), 32'd1);
        check("t3_locked",     32'(b8.locked),  32'd1);
        b8.clr_cnt = 1'b1;
        tick();
        b8.clr_cnt = 1'b0;
        check("t3_clr", 32'(b8.err_cnt), 32'd0);

        // Test 4: all-ones while locked forces re-hunt; all-zeros never locks.
        loop_en = 1'b0; tb_valid = 1'b1; tb_data = 8'hFF;
        for (int k = 0; k < 4; k++) tick();
        check("t4_unlock_ones", 32'(b8.locked), 32'd0);
        tb_data = 8'h00;
        unl = 0; pul = 0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (b8.locked !== 1'b0) unl++;
            if (b8.err_pulse !== 1'b0) pul++;
        end
        check("t4_zero_locked_cycles", 32'(unl), 32'd0);
        check("t4_zero_err_pulses",    32'(pul), 32'd0);

        // Test 5: random multi-bit errors on alternate words saturate the 4-bit counter.
        loop_en = 1'b1;
        wait_lock("t5", 0, 13);
        pul = 0;
        for (int k = 0; k < 10; k++) begin
            flip = 8'($urandom_range(1, 255)) | 8'h81;
            tick();
            if (b8.err_pulse === 1'b1) pul++;
            flip = 8'h00;
            tick();
            if (b8.err_pulse === 1'b1) pul++;
        end
        check("t5_pulses",   32'(pul), 32'd10);
        check("t5_sat",      32'(b8.err_cnt), 32'd15);
        check("t5_locked",   32'(b8.locked),  32'd1);
        flip = 8'h81; b8.clr_cnt = 1'b1;
        tick();
        flip = 8'h00; b8.clr_cnt = 1'b0;
        check("t5_clr_pulse", 32'(b8.err_pulse), 32'd1);
        check("t5_clr_wins",  32'(b8.err_cnt),   32'd0);
        // Checker frozen while nothing is valid, even with corrupted data present.
        b8.gen_en = 1'b0;
        tick();
        flip = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t5_idle_valid%0d", k), 32'(b8.gen_valid), 32'd0);
            check($sformatf("t5_idle_pulse%0d", k), 32'(b8.err_pulse), 32'd0);
        end
        flip = 8'h00; b8.gen_en = 1'b1;
        unl = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (b8.locked !== 1'b1) unl++;
        end
        check("t5_resume_unlocked", 32'(unl), 32'd0);
        check("t5_resume_err_cnt",  32'(b8.err_cnt), 32'd0);

        // Test 6: mode change 11->01 drops lock and relocks on PRBS15.
        b8.mode = 2'b01;
        tick();
        check("t6_mode_unlock", 32'(b8.locked),    32'd0);
        check("t6_mode_valid",  32'(b8.gen_valid), 32'd0);
        wait_lock("t6a", 0, 13);
        flip = 8'h01;
        tick();
        flip = 8'h00;
        tick();
        check("t6_err_cnt", 32'(b8.err_cnt), 32'd1);
        // Asynchronous mid-stream reset, observed before the next clock edge.
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("t6_rst_gen_valid", 32'(b8.gen_valid), 32'd0);
        check("t6_rst_locked",    32'(b8.locked),    32'd0);
        check("t6_rst_err_cnt",   32'(b8.err_cnt),   32'd0);
        check("t6_rst_err_pulse", 32'(b8.err_pulse), 32'd0);
        check("t6_rst_w1_data",   32'(b1.gen_data),  32'd0);
        tick();
        rst_n = 1'b0;
        wait_lock("t6b", 0, 14);
        unl = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (b8.locked !== 1'b1) unl++;
        end
        check("t6_relock_unlocked", 32'(unl), 32'd0);
        check("t6_relock_err_cnt",  32'(b8.err_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
